neurone: RTL and testbench
==========================

# neurone

Single fixed-point neuron of the feed-forward network: computes a weighted sum of nine signed inputs with nine signed weights, rescales it, applies an activation, and flags completion. Instances are tiled nine-wide per layer. Each layer's `end_` bits form the next layer's 9-bit `start_` vector, so layers chain through a level handshake.

## Interface
- `FRAC_BITS`, default 13: fractional bits of the weights (8192 = 1.0). The product sum is shifted right by this amount.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start_` input 9: per-source valid bits. Computation is requested only when all nine bits are 1.
- `weight_0` … `weight_8` input 17 each: signed weights, two's complement.
- `input_0` … `input_8` input 27 each: signed operands, two's complement.
- `out` output 27: signed, activated result. Holds its value until the next completed computation.
- `end_` output 1: result-valid level.

## Operation
- `go` = (`start_` == 9'h1FF).
- A trigger is a registered rising edge of `go`, i.e. `go` is high now and was low on the previous cycle.
- FSM states: IDLE, MAC, ACT, DONE.
  - IDLE: on trigger, latch all 9 inputs and 9 weights, clear the accumulator, set idx=0, go to MAC.
  - MAC: each cycle, acc += input[idx] × weight[idx]. Each product is a 44-bit signed value; the accumulator is 48-bit signed. After idx=8, go to ACT.
  - ACT: compute s = acc >>> FRAC_BITS (arithmetic shift, truncation toward −inf). Saturate s to [−2^26, 2^26−1], apply the activation, register the result to `out`, set `end_`=1, go to DONE.
  - DONE: hold `out` and `end_`=1 while `go` stays high. When `go`=0, clear `end_` on the next edge and go to IDLE.
- Abort: if `go` falls during MAC or ACT, return to IDLE. `end_` stays 0 and `out` keeps its previous value.
- A new computation requires `go` to fall and rise again. Holding `go` high never retriggers.
- Input and weight changes after the trigger edge have no effect on the current computation.

## Timing
- Reset (async assert, sync release): `out`=0, `end_`=0, state=IDLE, acc=0, `go` history=1. The history value of 1 means `start_` already at all-ones coming out of reset does not trigger.
- Latency from trigger edge E0:
  - MAC accumulates terms 0..8 at edges E1..E9.
  - `out` is valid and `end_` rises at edge E10.
- All nine instances of a layer have identical latency, so their `end_` bits rise together. This gives the next layer a clean all-ones trigger.
- `end_` falls one edge after `go` falls.
- Throughput: one result per 11+ cycles, including the drop of `go`.
- Reset asserted mid-operation: immediate return to reset values.

## Configuration
- `NEURONE_RELU_EN` defined: activation is ReLU, i.e. negative saturated sums produce `out`=0.
- `NEURONE_RELU_EN` undefined: activation is identity, so `out` = saturated s, including negative values.

## Test plan
- Reset: hold `rst_n`=0 with `start_`=9'h1FF → `out`=0, `end_`=0. Release with `start_` still all-ones → no trigger, `end_` stays 0.
- Basic sum: all weights 8192, `input_k`=k+1, `start_` 0→9'h1FF → `out`=45, `end_` rises exactly 10 edges after the trigger edge and holds while `start_` is held.
- Sign and activation: `weight_0`=−8192, others 0, `input_0`=100:
  - with `NEURONE_RELU_EN` → `out`=0;
  - without it → `out`=−100.
- Saturation: all inputs 2^26−1, all weights 65535 → `out`=67108863. With every weight negated (the ReLU-off build) → `out`=−67108864.
- Partial/abort:
  - `start_`=9'h1FE for 20 cycles → `end_` never rises.
  - Full start, then drop one bit at E5 → `end_` stays 0 and `out` is unchanged.
- Handshake: after `end_`=1, drive `start_`=0 → `end_`=0 one edge later. Raise `start_` with new inputs → new `out` after 10 edges.

Source files
------------

// File: rtl/neurone.sv
// Fixed-point neuron: nine-term signed MAC, rescale by FRAC_BITS, saturate, activate.
// Optional feature macro: NEURONE_RELU_EN (ReLU activation instead of identity).
module neurone #(
  parameter int FRAC_BITS = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [8:0]         start_,
  input  logic signed [16:0] weight_0,
  input  logic signed [16:0] weight_1,
  input  logic signed [16:0] weight_2,
  input  logic signed [16:0] weight_3,
  input  logic signed [16:0] weight_4,
  input  logic signed [16:0] weight_5,
  input  logic signed [16:0] weight_6,
  input  logic signed [16:0] weight_7,
  input  logic signed [16:0] weight_8,
  input  logic signed [26:0] input_0,
  input  logic signed [26:0] input_1,
  input  logic signed [26:0] input_2,
  input  logic signed [26:0] input_3,
  input  logic signed [26:0] input_4,
  input  logic signed [26:0] input_5,
  input  logic signed [26:0] input_6,
  input  logic signed [26:0] input_7,
  input  logic signed [26:0] input_8,
  output logic signed [26:0] out,
  output logic               end_
);

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, ACT = 2'd2, DONE = 2'd3} state_t;

  localparam logic signed [47:0] SAT_MAX = 48'sd67108863;
  localparam logic signed [47:0] SAT_MIN = -48'sd67108864;

  state_t              state_r, state_nxt_s;
  logic                go_s, go_d_r, trig_s;
  logic                load_s, mac_s, fin_s, clr_end_s;
  logic [3:0]          idx_r;
  logic signed [47:0]  acc_r;
  logic signed [43:0]  prod_s;
  logic signed [47:0]  shifted_s;
  logic signed [26:0]  sat_s, act_s;
  logic signed [16:0]  w_in_s [0:8];
  logic signed [26:0]  x_in_s [0:8];
  logic signed [16:0]  w_r    [0:8];
  logic signed [26:0]  x_r    [0:8];

  assign w_in_s[0] = weight_0;
  assign w_in_s[1] = weight_1;
  assign w_in_s[2] = weight_2;
  assign w_in_s[3] = weight_3;
  assign w_in_s[4] = weight_4;
  assign w_in_s[5] = weight_5;
  assign w_in_s[6] = weight_6;
  assign w_in_s[7] = weight_7;
  assign w_in_s[8] = weight_8;
  assign x_in_s[0] = input_0;
  assign x_in_s[1] = input_1;
  assign x_in_s[2] = input_2;
  assign x_in_s[3] = input_3;
  assign x_in_s[4] = input_4;
  assign x_in_s[5] = input_5;
  assign x_in_s[6] = input_6;
  assign x_in_s[7] = input_7;
  assign x_in_s[8] = input_8;

  // Only a fresh low-to-high transition of the all-ones start vector triggers.
  assign go_s   = (start_ == 9'h1FF);
  assign trig_s = go_s & ~go_d_r;

  assign prod_s    = x_r[idx_r] * w_r[idx_r];
  assign shifted_s = acc_r >>> FRAC_BITS;

  // Saturate the rescaled sum to 27 bits and apply the activation.
  always_comb begin
    sat_s = shifted_s[26:0];
    act_s = 27'sd0;
    if (shifted_s > SAT_MAX) begin
      sat_s = SAT_MAX[26:0];
    end else if (shifted_s < SAT_MIN) begin
      sat_s = SAT_MIN[26:0];
    end else begin
      sat_s = shifted_s[26:0];
    end
`ifdef NEURONE_RELU_EN
    if (sat_s[26]) begin
      act_s = 27'sd0;
    end else begin
      act_s = sat_s;
    end
`else
    act_s = sat_s;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath control; losing go mid-computation aborts to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    mac_s       = 1'b0;
    fin_s       = 1'b0;
    clr_end_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (trig_s) begin
          load_s      = 1'b1;
          state_nxt_s = MAC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MAC: begin
        if (!go_s) begin
          state_nxt_s = IDLE;
        end else begin
          mac_s = 1'b1;
          if (idx_r == 4'd8) begin
            state_nxt_s = ACT;
          end else begin
            state_nxt_s = MAC;
          end
        end
      end
      ACT: begin
        if (!go_s) begin
          state_nxt_s = IDLE;
        end else begin
          fin_s       = 1'b1;
          state_nxt_s = DONE;
        end
      end
      DONE: begin
        if (!go_s) begin
          clr_end_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Operand capture, accumulation and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_d_r <= 1'b1;
      idx_r  <= 4'd0;
      acc_r  <= 48'sd0;
      out    <= 27'sd0;
      end_   <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        w_r[i] <= 17'sd0;
        x_r[i] <= 27'sd0;
      end
    end else begin
      go_d_r <= go_s;
      if (load_s) begin
        idx_r <= 4'd0;
        acc_r <= 48'sd0;
        for (int i = 0; i < 9; i++) begin
          w_r[i] <= w_in_s[i];
          x_r[i] <= x_in_s[i];
        end
      end else if (mac_s) begin
        idx_r <= idx_r + 4'd1;
        acc_r <= acc_r + {{4{prod_s[43]}}, prod_s};
      end else begin
        idx_r <= idx_r;
        acc_r <= acc_r;
      end
      if (fin_s) begin
        out  <= act_s;
        end_ <= 1'b1;
      end else if (clr_end_s) begin
        out  <= out;
        end_ <= 1'b0;
      end else begin
        out  <= out;
        end_ <= end_;
      end
    end
  end

endmodule

// File: tb/tb_neurone.sv
// Directed self-checking bench for neurone; expected values hand-computed.
module tb_neurone;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [8:0]         start_ = 9'h1FF;
  logic signed [16:0] w_v [0:8];
  logic signed [26:0] in_v [0:8];
  logic signed [26:0] out;
  logic               end_;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  int seen;
  int prev_out;

  always #5 clk = ~clk;

  neurone #(.FRAC_BITS(13)) dut (
    .clk(clk), .rst_n(rst_n), .start_(start_),
    .weight_0(w_v[0]), .weight_1(w_v[1]), .weight_2(w_v[2]),
    .weight_3(w_v[3]), .weight_4(w_v[4]), .weight_5(w_v[5]),
    .weight_6(w_v[6]), .weight_7(w_v[7]), .weight_8(w_v[8]),
    .input_0(in_v[0]), .input_1(in_v[1]), .input_2(in_v[2]),
    .input_3(in_v[3]), .input_4(in_v[4]), .input_5(in_v[5]),
    .input_6(in_v[6]), .input_7(in_v[7]), .input_8(in_v[8]),
    .out(out), .end_(end_)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drop start_, raise it (trigger edge E0), scramble operands, then time end_.
  task automatic run_op(input string tag);
    start_ = 9'h000;
    repeat (2) @(negedge clk);
    start_ = 9'h1FF;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      in_v[k] = 27'($urandom);
      w_v[k]  = 17'($urandom);
    end
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (end_) begin
        lat = k;
        break;
      end
    end
    check_val({tag, "_latency"}, lat, 10);
  endtask

  task automatic set_all(input int x0, input int xstep, input int w);
    for (int k = 0; k < 9; k++) begin
      in_v[k] = 27'(x0 + k * xstep);
      w_v[k]  = 17'(w);
    end
  endtask

  initial begin
    set_all(0, 0, 0);
    repeat (3) @(negedge clk);
    check_val("rst_out", out, 0);
    check_val("rst_end", end_, 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (end_) seen++;
    end
    check_val("no_trig_after_rst", seen, 0);

    // Basic sum 1+..+9 with unity weights.
    @(negedge clk);
    set_all(1, 1, 8192);
    run_op("basic");
    check_val("basic_out", out, 45);
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (end_) seen++;
    end
    check_val("basic_hold_end", seen, 5);
    check_val("basic_hold_out", out, 45);
    @(negedge clk);
    start_ = 9'h000;
    @(posedge clk);
    #1;
    check_val("end_fall", end_, 0);

    // Single negative weight.
    @(negedge clk);
    set_all(0, 0, 0);
    w_v[0] = -17'sd8192;
    in_v[0] = 27'sd100;
    run_op("sign");
`ifdef NEURONE_RELU_EN
    check_val("sign_out", out, 0);
`else
    check_val("sign_out", out, -100);
`endif

    // Alternating signs: 1-2+3-4+5-6+7-8+9 = 5.
    @(negedge clk);
    set_all(1, 1, 8192);
    for (int k = 1; k < 9; k += 2) w_v[k] = -17'sd8192;
    run_op("alt");
    check_val("alt_out", out, 5);

    // Half weights: 27*0.5 = 13.5 truncates to 13; negated floors to -14.
    @(negedge clk);
    set_all(3, 0, 4096);
    run_op("half");
    check_val("half_out", out, 13);
    @(negedge clk);
    set_all(3, 0, -4096);
    run_op("nhalf");
`ifdef NEURONE_RELU_EN
    check_val("nhalf_out", out, 0);
`else
    check_val("nhalf_out", out, -14);
`endif

    // Saturation both ways.
    @(negedge clk);
    set_all(67108863, 0, 65535);
    run_op("satp");
    check_val("satp_out", out, 67108863);
    @(negedge clk);
    set_all(67108863, 0, -65535);
    run_op("satn");
`ifdef NEURONE_RELU_EN
    check_val("satn_out", out, 0);
`else
    check_val("satn_out", out, -67108864);
`endif

    // Establish a known out before the partial/abort cases.
    @(negedge clk);
    set_all(1, 1, 8192);
    run_op("pre");
    check_val("pre_out", out, 45);
    prev_out = out;

    // Partial start vector never triggers.
    @(negedge clk);
    start_ = 9'h000;
    @(negedge clk);
    start_ = 9'h1FE;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (end_) seen++;
    end
    check_val("partial_end", seen, 0);
    check_val("partial_out", out, prev_out);

    // Abort: drop one start bit after E5.
    @(negedge clk);
    start_ = 9'h000;
    set_all(1, 0, 8192);
    repeat (2) @(negedge clk);
    start_ = 9'h1FF;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start_ = 9'h0FF;
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (end_) seen++;
    end
    check_val("abort_end", seen, 0);
    check_val("abort_out", out, prev_out);

    // Fresh handshake with new operands: 2*(1+..+9) = 90.
    @(negedge clk);
    set_all(2, 2, 8192);
    run_op("again");
    check_val("again_out", out, 90);

    // Reset mid-computation clears outputs immediately.
    @(negedge clk);
    start_ = 9'h000;
    set_all(1, 1, 8192);
    repeat (2) @(negedge clk);
    start_ = 9'h1FF;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midrst_out", out, 0);
    check_val("midrst_end", end_, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
